// File: rtl/mac_pkg.sv
// mac_pkg: shared types for the MAC feeder slice.
//   DATA_W / ACC_W   default operand and MAC product widths
//   feeder_state_e   sequencing FSM states of mac_feeder
//   mac_pair_t       one buffered operand pair {last, m, q}
package mac_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } feeder_state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] q;
    } mac_pair_t;

endpackage

// File: rtl/mac_feeder_fifo.sv
// mac_feeder_fifo: synchronous FIFO of mac_pair_t.
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data (ignored while full)
//   pop, dout    read request (ignored while empty); dout shows the head
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
module mac_feeder_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  mac_pair_t                din,
    input  logic                     pop,
    output mac_pair_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    mac_pair_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid, so clearing the data is wasted logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: buffers signed operand pairs and issues them one at a time to
// mac_top over its start/ready handshake. Because mac_top never clears, each
// vector's dot product is reported as (final product - snapshot taken just
// before the vector's first issue), modulo 2^ACC_W.
//   clk, rst                        clock, asynchronous active-high reset
//   s_valid/s_ready, s_m/s_q/s_last operand pair input stream
//   mac_start, mac_m, mac_q         issue pulse and operands to mac_top
//   mac_ready, mac_product          completion and running product from mac_top
//   res_valid/res_ready             result handshake
//   res_data, res_count             vector dot product and pair count
//   busy                            FSM active or FIFO holding pairs
module mac_feeder #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_m,
    input  logic [DATA_W-1:0] s_q,
    input  logic              s_last,
    output logic              mac_start,
    output logic [DATA_W-1:0] mac_m,
    output logic [DATA_W-1:0] mac_q,
    input  logic              mac_ready,
    input  logic [ACC_W-1:0]  mac_product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy
);

    import mac_pkg::*;

    feeder_state_e          state;
    feeder_state_e          state_nxt;
    mac_pair_t              in_pair;
    mac_pair_t              head;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   first_q;
    logic                   last_q;
    logic [DATA_W-1:0]      mac_m_q;
    logic [DATA_W-1:0]      mac_q_q;
    logic [ACC_W-1:0]       base_q;
    logic [CNT_W-1:0]       count_q;

    assign in_pair = {s_last, s_m, s_q};

    mac_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .din   (in_pair),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fifo_pop  = 1'b1;
                state_nxt = ST_WAIT;
            end
            // ISSUE lasts one cycle, so the ready seen alongside mac_start is
            // never examined here; WAIT only looks at later cycles.
            ST_WAIT: begin
                if (mac_ready) begin
                    if (last_q) begin
                        state_nxt = ST_OUT;
                    end else if (!fifo_empty) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    state_nxt = fifo_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_m_q   <= '0;
            mac_q_q   <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            base_q    <= '0;
            count_q   <= '0;
            res_data  <= '0;
            res_count <= '0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    mac_m_q <= head.m;
                    mac_q_q <= head.q;
                    last_q  <= head.last;
                    if (first_q) begin
                        // Snapshot the running product before this vector's
                        // first pair contributes to it.
                        base_q  <= mac_product;
                        first_q <= 1'b0;
                        count_q <= CNT_W'(1);
                    end else if (count_q != '1) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mac_ready && last_q) begin
                        // Wrapping subtraction stays correct across MAC overflow.
                        res_data  <= mac_product - base_q;
                        res_count <= count_q;
                        first_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The head is shown directly during ISSUE so the operands are valid in the
    // mac_start cycle; the registered copy holds them until completion.
    assign mac_start = (state == ST_ISSUE);
    assign mac_m     = (state == ST_ISSUE) ? head.m : mac_m_q;
    assign mac_q     = (state == ST_ISSUE) ? head.q : mac_q_q;
    assign s_ready   = !fifo_full;
    assign res_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_m = '0;
    logic [DATA_W-1:0] s_q = '0;
    logic              s_last = 1'b0;
    logic              mac_start;
    logic [DATA_W-1:0] mac_m;
    logic [DATA_W-1:0] mac_q;
    logic              mac_ready = 1'b1;
    logic [ACC_W-1:0]  mac_product = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic              busy;

    always #5 clk = ~clk;

    mac_feeder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_m         (s_m),
        .s_q         (s_q),
        .s_last      (s_last),
        .mac_start   (mac_start),
        .mac_m       (mac_m),
        .mac_q       (mac_q),
        .mac_ready   (mac_ready),
        .mac_product (mac_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_count   (res_count),
        .busy        (busy)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] cnt;
    } res_t;

    res_t                exp_res[$];
    logic [2*DATA_W-1:0] exp_issue[$];
    logic [ACC_W-1:0]    model_sum = '0;
    int                  model_n = 0;

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0;
    int n_res = 0;
    logic [ACC_W-1:0] last_res_data = '0;
    logic [CNT_W-1:0] last_res_count = '0;
    logic [2*DATA_W-1:0] prev_mq = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural mac_top ----------------
    // Accumulates m*q forever; ready drops for lat-1 cycles after a start and
    // the new product appears with ready. Latency 1 keeps ready high always.
    int                     lat_min = 1;
    int                     lat_max = 4;
    int                     mac_cnt = 0;
    logic [ACC_W-1:0]       mac_acc = '0;
    logic [ACC_W-1:0]       mac_pend = '0;
    logic [ACC_W-1:0]       mac_nxt;
    logic signed [2*DATA_W-1:0] mac_prod;
    logic                   preload_req = 1'b0;
    logic [ACC_W-1:0]       preload_val = '0;
    int                     mac_lat;

    always @(posedge clk) begin
        if (preload_req) begin
            mac_acc     <= preload_val;
            mac_product <= preload_val;
        end else if (mac_start) begin
            mac_prod = $signed(mac_m) * $signed(mac_q);
            mac_nxt  = mac_acc + {{(ACC_W-2*DATA_W){mac_prod[2*DATA_W-1]}}, mac_prod};
            mac_lat  = $urandom_range(lat_max, lat_min);
            mac_acc  <= mac_nxt;
            if (mac_lat == 1) begin
                mac_product <= mac_nxt;
                mac_ready   <= 1'b1;
            end else begin
                mac_pend  <= mac_nxt;
                mac_ready <= 1'b0;
                mac_cnt   <= mac_lat - 1;
            end
        end else if (mac_cnt != 0) begin
            mac_cnt <= mac_cnt - 1;
            if (mac_cnt == 1) begin
                mac_product <= mac_pend;
                mac_ready   <= 1'b1;
            end
        end
    end

    // ---------------- result-ready driver ----------------
    int rr_mode = 1;  // 0: hold low, 1: always high, 2: random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        res_t e;
        logic [2*DATA_W-1:0] ei;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_mq = '0;
            end else begin
                if (mac_start) begin
                    n_start++;
                    if (exp_issue.size() == 0) begin
                        check("issue_unexpected", 64'(mac_start), 64'd0);
                    end else begin
                        ei = exp_issue.pop_front();
                        check("issue_operands", 64'({mac_m, mac_q}), 64'(ei));
                    end
                    prev_mq = {mac_m, mac_q};
                end else begin
                    check("operand_hold", 64'({mac_m, mac_q}), 64'(prev_mq));
                end
                if (res_valid && res_ready) begin
                    n_res++;
                    last_res_data  = res_data;
                    last_res_count = res_count;
                    if (exp_res.size() == 0) begin
                        check("result_unexpected", 64'(res_valid), 64'd0);
                    end else begin
                        e = exp_res.pop_front();
                        check("res_data", 64'(res_data), 64'(e.data));
                        check("res_count", 64'(res_count), 64'(e.cnt));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Reference: a vector's result is the plain sum of its m*q products mod
    // 2^ACC_W, and its count is the number of pairs clipped to 2^CNT_W-1.
    task automatic push_pair(input logic signed [DATA_W-1:0] m,
                             input logic signed [DATA_W-1:0] q,
                             input logic last);
        int guard;
        logic signed [2*DATA_W-1:0] p;
        res_t r;
        s_valid = 1'b1;
        s_m     = m;
        s_q     = q;
        s_last  = last;
        guard   = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!s_ready && guard < 500);
        if (!s_ready) begin
            check("push_timeout_s_ready", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        p = m * q;
        exp_issue.push_back({m, q});
        model_sum = model_sum + {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
        model_n++;
        if (last) begin
            r.data = model_sum;
            r.cnt  = (model_n > (2**CNT_W - 1)) ? CNT_W'(2**CNT_W - 1) : CNT_W'(model_n);
            exp_res.push_back(r);
            model_sum = '0;
            model_n   = 0;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_res.size() != 0 || exp_issue.size() != 0 || busy) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            check("drain_timeout_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mac_idle();
        int g = 0;
        while (mac_cnt != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"},   64'(s_ready),   64'd1);
        check({tag, "_mac_start"}, 64'(mac_start), 64'd0);
        check({tag, "_mac_m"},     64'(mac_m),     64'd0);
        check({tag, "_mac_q"},     64'(mac_q),     64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_data"},  64'(res_data),  64'd0);
        check({tag, "_res_count"}, 64'(res_count), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        int s1;
        int g;
        logic last;

        // Reset values
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Push-to-start latency, then first vector: 10*10 + 5*2 = 110
        s0 = n_start;
        push_pair(16'sd10, 16'sd10, 1'b0);
        @(negedge clk);
        check("latency_t1_no_start", 64'(mac_start), 64'd0);
        check("latency_t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("latency_t2_start", 64'(mac_start), 64'd1);
        @(posedge clk);
        #1;
        push_pair(16'sd5, 16'sd2, 1'b1);
        wait_drain();
        check("vec1_starts", 64'(n_start - s0), 64'd2);
        check("vec1_data", 64'(last_res_data), 64'd110);
        check("vec1_count", 64'(last_res_count), 64'd2);

        // Negative result: 2*-3 = -6
        push_pair(16'sd2, -16'sd3, 1'b1);
        wait_drain();
        check("vec2_data_neg", 64'(last_res_data), 64'hFF_FFFF_FFFA);
        check("vec2_count", 64'(last_res_count), 64'd1);

        // Result held: FIFO fills behind it, nothing issues until handshake
        rr_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        push_pair(16'sd1, 16'sd1, 1'b1);
        g = 0;
        while (!res_valid && g < 100) begin @(negedge clk); g++; end
        check("hold_res_valid", 64'(res_valid), 64'd1);
        @(posedge clk);
        #1;
        s0 = n_start;
        for (int i = 0; i < DEPTH; i++) begin
            push_pair(DATA_W'($urandom), DATA_W'($urandom), (i == DEPTH - 1));
        end
        @(negedge clk);
        check("full_s_ready", 64'(s_ready), 64'd0);
        check("full_no_start", 64'(n_start - s0), 64'd0);
        check("full_res_valid", 64'(res_valid), 64'd1);
        check("full_res_data_held", 64'(res_data), 64'd1);
        repeat (5) @(negedge clk);
        check("full_no_start_later", 64'(n_start - s0), 64'd0);
        rr_mode = 1;
        wait_drain();
        check("full_drain_starts", 64'(n_start - s0), 64'(DEPTH));

        // MAC product wraps inside a vector: (2^40-5) + 9 = 4, result 9
        wait_mac_idle();
        preload_val = 40'hFF_FFFF_FFFB;
        preload_req = 1'b1;
        @(posedge clk);
        #1;
        preload_req = 1'b0;
        push_pair(16'sd3, 16'sd3, 1'b1);
        wait_drain();
        check("wrap_data", 64'(last_res_data), 64'd9);

        // Reset during WAIT with three pairs queued
        lat_min = 4;
        lat_max = 4;
        s0 = n_start;
        push_pair(16'sd1, 16'sd2, 1'b0);
        push_pair(16'sd3, 16'sd4, 1'b0);
        push_pair(16'sd5, 16'sd6, 1'b0);
        push_pair(16'sd7, 16'sd8, 1'b0);
        check("midrst_one_issued", 64'(n_start - s0), 64'd1);
        check("midrst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        exp_issue.delete();
        model_sum = '0;
        model_n   = 0;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_mac_idle();
        lat_min = 1;
        lat_max = 4;
        push_pair(16'sd4, 16'sd4, 1'b1);
        wait_drain();
        check("postrst_data", 64'(last_res_data), 64'd16);
        check("postrst_count", 64'(last_res_count), 64'd1);

        // mac_ready held high throughout: one completion per issue
        lat_min = 1;
        lat_max = 1;
        s0 = n_start;
        s1 = n_res;
        push_pair(-16'sd7, 16'sd300, 1'b0);
        push_pair(16'sd1000, -16'sd1000, 1'b0);
        push_pair(16'sd12, 16'sd12, 1'b1);
        wait_drain();
        check("rdyhigh_starts", 64'(n_start - s0), 64'd3);
        check("rdyhigh_results", 64'(n_res - s1), 64'd1);

        // Pair count saturates
        for (int i = 0; i < 260; i++) begin
            push_pair(16'sd1, 16'sd1, (i == 259));
        end
        wait_drain();
        check("sat_count", 64'(last_res_count), 64'd255);
        check("sat_data", 64'(last_res_data), 64'd260);

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        rr_mode = 2;
        for (int i = 0; i < 80; i++) begin
            last = ($urandom_range(0, 3) == 0) || (i == 79);
            push_pair(DATA_W'($urandom), DATA_W'($urandom), last);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_drain();
        rr_mode = 1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("end_idle_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
